// File: rtl/hash_mailbox_pkg.sv
// Shared constants and state encoding for the SHA-256 result mailbox.
package hash_mailbox_pkg;

    localparam logic [3:0] OFF_WORD0 = 4'd0;
    localparam logic [3:0] OFF_CTRL  = 4'd8;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_CLEAR  = 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DONE    = 2'd1,
        FAULT   = 2'd2
    } state_t;

endpackage

// File: rtl/hash_mailbox.sv
// Snoops CPU stores to a 9-word region, stages eight digest words and presents
// the committed 256-bit digest to the display driver with a cycle count.
module hash_mailbox
    import hash_mailbox_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR = 12'hF00,
    parameter int          CNT_W     = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wren,
    input  logic [11:0]      address_dmem,
    input  logic [31:0]      data,
    output logic [255:0]     hash_value,
    output logic             finished,
    output logic             done_pulse,
    output logic             fault,
    output logic [7:0]       valid_mask,
    output logic [CNT_W-1:0] hash_cycles,
    output state_t           fsm_state
);

    // Handshake: none. The bus write is a single-cycle store qualified by wren;
    // this block only observes it and never stalls the RAM.

    state_t            state;
    state_t            state_next;
    logic [11:0]       rel_addr;
    logic [3:0]        offset;
    logic [2:0]        word_idx;
    logic              hit;
    logic              word_wr;
    logic              ctrl_wr;
    logic              do_clear;
    logic              do_commit;
    logic              do_fault;
    logic [31:0]       staging [8];
    logic [255:0]      staging_flat;
    logic [CNT_W-1:0]  cnt;

    // Addresses below BASE_ADDR wrap to large values and fall outside the window.
    assign rel_addr = address_dmem - BASE_ADDR;
    assign hit      = wren && (rel_addr <= 12'(OFF_CTRL));
    assign offset   = rel_addr[3:0];
    assign word_idx = 3'(offset - OFF_WORD0);
    assign word_wr  = hit && (offset < OFF_CTRL);
    assign ctrl_wr  = hit && (offset == OFF_CTRL);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            staging_flat[255 - 32*i -: 32] = staging[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        do_commit  = 1'b0;
        do_fault   = 1'b0;
        if (ctrl_wr) begin
            if (data[CTRL_CLEAR]) begin
                do_clear   = 1'b1;
                state_next = COLLECT;
            end else if (data[CTRL_COMMIT] && (state != FAULT)) begin
                if (valid_mask == 8'hFF) begin
                    do_commit  = 1'b1;
                    state_next = DONE;
                end else begin
                    do_fault   = 1'b1;
                    state_next = FAULT;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                staging[i] <= '0;
            end
            valid_mask <= '0;
        end else if (do_clear) begin
            for (int i = 0; i < 8; i++) begin
                staging[i] <= '0;
            end
            valid_mask <= '0;
        end else if (word_wr) begin
            staging[word_idx]    <= data;
            valid_mask[word_idx] <= 1'b1;
        end
    end

    // hash_value is a second buffer so staging can be refilled while DONE is shown.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hash_value <= '0;
            finished   <= 1'b0;
            done_pulse <= 1'b0;
            fault      <= 1'b0;
        end else begin
            done_pulse <= do_commit;
            if (do_clear) begin
                finished <= 1'b0;
                fault    <= 1'b0;
            end else if (do_commit) begin
                hash_value <= staging_flat;
                finished   <= 1'b1;
            end else if (do_fault) begin
                fault <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (do_clear) begin
            cnt <= '0;
        end else if ((state == COLLECT) && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign hash_cycles = cnt;
    assign fsm_state   = state;

endmodule

// File: tb/tb_hash_mailbox.sv
// Self-checking bench for hash_mailbox: directed scenarios plus random bus traffic
// compared against a behavioural mailbox model.
module tb_hash_mailbox;
    import hash_mailbox_pkg::*;

    localparam logic [11:0] BASE = 12'hF00;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         wren = 1'b0;
    logic [11:0]  address_dmem = '0;
    logic [31:0]  data = '0;

    logic [255:0] hash_value, hash_value4;
    logic         finished, finished4;
    logic         done_pulse, done_pulse4;
    logic         fault, fault4;
    logic [7:0]   valid_mask, valid_mask4;
    logic [31:0]  hash_cycles;
    logic [3:0]   hash_cycles4;
    state_t       fsm_state, fsm_state4;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model of the mailbox as seen by software.
    logic [31:0]  m_stage [8];
    logic [7:0]   m_mask;
    logic [255:0] m_hash;
    bit           m_fin, m_pulse, m_fault;
    int           m_phase;           // 0 collecting, 1 digest shown, 2 faulted
    longint       m_cnt;

    logic [31:0] iv [8] = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
                            32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};

    hash_mailbox #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .wren(wren), .address_dmem(address_dmem), .data(data),
        .hash_value(hash_value), .finished(finished), .done_pulse(done_pulse), .fault(fault),
        .valid_mask(valid_mask), .hash_cycles(hash_cycles), .fsm_state(fsm_state)
    );

    hash_mailbox #(.BASE_ADDR(BASE), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .wren(wren), .address_dmem(address_dmem), .data(data),
        .hash_value(hash_value4), .finished(finished4), .done_pulse(done_pulse4), .fault(fault4),
        .valid_mask(valid_mask4), .hash_cycles(hash_cycles4), .fsm_state(fsm_state4)
    );

    always #5 clock = ~clock;

    function automatic logic [255:0] m_pack();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[255 - 32*i -: 32] = m_stage[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_stage[i] = '0;
        m_mask = '0; m_hash = '0; m_fin = 0; m_pulse = 0; m_fault = 0; m_phase = 0; m_cnt = 0;
    endtask

    task automatic model_apply(input logic we, input logic [11:0] a, input logic [31:0] d);
        bit collecting;
        bit cleared;
        int off;
        collecting = (m_phase == 0);
        cleared = 0;
        m_pulse = 0;
        if (we && a >= BASE && a <= BASE + 12'd8) begin
            off = int'(a - BASE);
            if (off < 8) begin
                m_stage[off] = d;
                m_mask[off] = 1'b1;
            end else if (d[1]) begin
                for (int i = 0; i < 8; i++) m_stage[i] = '0;
                m_mask = '0; m_fin = 0; m_fault = 0; m_phase = 0; m_cnt = 0;
                cleared = 1;
            end else if (d[0] && m_phase != 2) begin
                if (m_mask == 8'hFF) begin
                    m_hash = m_pack(); m_fin = 1; m_pulse = 1; m_phase = 1;
                end else begin
                    m_fault = 1; m_phase = 2;
                end
            end
        end
        if (collecting && !cleared && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    endtask

    // Drives one bus cycle from the low clock phase; returns at the next negedge.
    task automatic step(input logic we, input logic [11:0] a, input logic [31:0] d);
        wren = we; address_dmem = a; data = d;
        @(posedge clock);
        model_apply(we, a, d);
        @(negedge clock);
    endtask

    task automatic idle();
        step(1'b0, 12'h000, 32'h0);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clock);
        vectors++; if (hash_value !== 256'h0) begin miscompares++; $display("FAIL reset_hash: got %h exp 0", hash_value); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL reset_finished: got %b exp 0", finished); end
        vectors++; if (done_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_pulse: got %b exp 0", done_pulse); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b exp 0", fault); end
        vectors++; if (valid_mask !== 8'h0) begin miscompares++; $display("FAIL reset_mask: got %h exp 0", valid_mask); end
        vectors++; if (hash_cycles !== 32'h0) begin miscompares++; $display("FAIL reset_cycles: got %0d exp 0", hash_cycles); end
        vectors++; if (fsm_state !== COLLECT) begin miscompares++; $display("FAIL reset_state: got %0d exp 0", fsm_state); end
        #1 reset = 1'b1;
    endtask

    task automatic test_counter();
        for (int i = 0; i < 8; i++) step(1'b1, BASE + 12'(i), iv[i]);
        repeat (91) idle();
        step(1'b1, BASE + 12'd8, 32'h1);
        vectors++; if (hash_cycles !== 32'd100) begin miscompares++; $display("FAIL cnt_100: got %0d exp 100", hash_cycles); end
        vectors++; if (hash_cycles4 !== 4'd15) begin miscompares++; $display("FAIL cnt_sat4: got %0d exp 15", hash_cycles4); end
        vectors++; if (done_pulse !== 1'b1) begin miscompares++; $display("FAIL cnt_pulse: got %b exp 1", done_pulse); end
        repeat (5) idle();
        vectors++; if (hash_cycles !== 32'd100) begin miscompares++; $display("FAIL cnt_frozen: got %0d exp 100", hash_cycles); end
        vectors++; if (hash_cycles4 !== 4'd15) begin miscompares++; $display("FAIL cnt_sat4_hold: got %0d exp 15", hash_cycles4); end
    endtask

    task automatic test_commit();
        step(1'b1, BASE + 12'd8, 32'h2);
        for (int i = 0; i < 8; i++) step(1'b1, BASE + 12'(i), iv[i]);
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL commit_early_fin: got %b exp 0", finished); end
        step(1'b1, BASE + 12'd8, 32'h1);
        vectors++; if (hash_value[255:224] !== 32'h6A09E667) begin miscompares++; $display("FAIL commit_word0: got %h exp 6a09e667", hash_value[255:224]); end
        vectors++; if (hash_value[31:0] !== 32'h5BE0CD19) begin miscompares++; $display("FAIL commit_word7: got %h exp 5be0cd19", hash_value[31:0]); end
        vectors++; if (hash_value !== m_hash) begin miscompares++; $display("FAIL commit_hash: got %h exp %h", hash_value, m_hash); end
        vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL commit_finished: got %b exp 1", finished); end
        vectors++; if (done_pulse !== 1'b1) begin miscompares++; $display("FAIL commit_pulse: got %b exp 1", done_pulse); end
        vectors++; if (valid_mask !== 8'hFF) begin miscompares++; $display("FAIL commit_mask: got %h exp ff", valid_mask); end
        vectors++; if (fsm_state !== DONE) begin miscompares++; $display("FAIL commit_state: got %0d exp 1", fsm_state); end
        idle();
        vectors++; if (done_pulse !== 1'b0) begin miscompares++; $display("FAIL commit_pulse_width: got %b exp 0", done_pulse); end
        vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL commit_fin_hold: got %b exp 1", finished); end
    endtask

    task automatic test_rewrite();
        logic [255:0] shown;
        logic [31:0]  frozen;
        shown = hash_value;
        frozen = hash_cycles;
        step(1'b1, BASE + 12'd3, 32'hDEADBEEF);
        vectors++; if (hash_value !== m_hash) begin miscompares++; $display("FAIL rewrite_hold: got %h exp %h", hash_value, m_hash); end
        vectors++; if (hash_value[159:128] === 32'hDEADBEEF) begin miscompares++; $display("FAIL rewrite_leak: got %h exp %h", hash_value[159:128], shown[159:128]); end
        vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL rewrite_fin: got %b exp 1", finished); end
        step(1'b1, BASE + 12'd8, 32'h1);
        vectors++; if (hash_value[159:128] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL recommit_word3: got %h exp deadbeef", hash_value[159:128]); end
        vectors++; if (done_pulse !== 1'b1) begin miscompares++; $display("FAIL recommit_pulse: got %b exp 1", done_pulse); end
        vectors++; if (hash_cycles !== frozen) begin miscompares++; $display("FAIL recommit_cycles: got %0d exp %0d", hash_cycles, frozen); end
    endtask

    task automatic test_partial();
        logic [255:0] shown;
        shown = hash_value;
        step(1'b1, BASE + 12'd8, 32'h2);
        for (int i = 0; i < 7; i++) step(1'b1, BASE + 12'(i), $urandom);
        step(1'b1, BASE - 12'd1, 32'hFFFF_FFFF);
        step(1'b1, BASE + 12'd9, 32'hFFFF_FFFF);
        step(1'b0, BASE + 12'd7, 32'h1234_5678);
        step(1'b0, BASE + 12'd8, 32'h1);
        vectors++; if (valid_mask !== 8'h7F) begin miscompares++; $display("FAIL partial_mask: got %h exp 7f", valid_mask); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL partial_noise_fin: got %b exp 0", finished); end
        step(1'b1, BASE + 12'd8, 32'h1);
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL partial_fault: got %b exp 1", fault); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL partial_fin: got %b exp 0", finished); end
        vectors++; if (hash_value !== shown) begin miscompares++; $display("FAIL partial_hash: got %h exp %h", hash_value, shown); end
        vectors++; if (done_pulse !== 1'b0) begin miscompares++; $display("FAIL partial_pulse: got %b exp 0", done_pulse); end
        vectors++; if (fsm_state !== FAULT) begin miscompares++; $display("FAIL partial_state: got %0d exp 2", fsm_state); end
        step(1'b1, BASE + 12'd7, 32'hCAFEF00D);
        step(1'b1, BASE + 12'd8, 32'h1);
        vectors++; if (done_pulse !== 1'b0) begin miscompares++; $display("FAIL fault_commit_pulse: got %b exp 0", done_pulse); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL fault_commit_fin: got %b exp 0", finished); end
        vectors++; if (valid_mask !== 8'hFF) begin miscompares++; $display("FAIL fault_mask: got %h exp ff", valid_mask); end
        step(1'b1, BASE + 12'd8, 32'h2);
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL clear_fault: got %b exp 0", fault); end
        vectors++; if (valid_mask !== 8'h00) begin miscompares++; $display("FAIL clear_mask: got %h exp 0", valid_mask); end
        vectors++; if (fsm_state !== COLLECT) begin miscompares++; $display("FAIL clear_state: got %0d exp 0", fsm_state); end
        vectors++; if (hash_cycles !== 32'd0) begin miscompares++; $display("FAIL clear_cycles: got %0d exp 0", hash_cycles); end
    endtask

    task automatic test_clear_priority();
        for (int i = 0; i < 8; i++) step(1'b1, BASE + 12'(i), $urandom);
        vectors++; if (valid_mask !== 8'hFF) begin miscompares++; $display("FAIL prio_full: got %h exp ff", valid_mask); end
        step(1'b1, BASE + 12'd8, 32'h3);
        vectors++; if (valid_mask !== 8'h00) begin miscompares++; $display("FAIL prio_mask: got %h exp 0", valid_mask); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL prio_fin: got %b exp 0", finished); end
        vectors++; if (done_pulse !== 1'b0) begin miscompares++; $display("FAIL prio_pulse: got %b exp 0", done_pulse); end
        idle();
        vectors++; if (done_pulse !== 1'b0) begin miscompares++; $display("FAIL prio_pulse_late: got %b exp 0", done_pulse); end
    endtask

    task automatic test_random();
        int r;
        logic [31:0] ctrl_pick [5];
        logic [11:0] a;
        step(1'b1, BASE + 12'd8, 32'h2);
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                step(1'b1, BASE + 12'($urandom_range(0, 7)), $urandom);
            end else if (r < 60) begin
                case ($urandom_range(0, 3))
                    0: a = BASE - 12'd1;
                    1: a = BASE + 12'd9;
                    2: a = 12'($urandom_range(0, 12'hEFF));
                    default: a = BASE + 12'($urandom_range(0, 8));
                endcase
                step(a < BASE || a > BASE + 12'd8, a, $urandom);
            end else if (r < 78) begin
                ctrl_pick = '{32'h0, 32'h1, 32'h1, 32'h2, $urandom};
                step(1'b1, BASE + 12'd8, ctrl_pick[$urandom_range(0, 4)]);
            end else begin
                idle();
            end
            vectors++; if (hash_value !== m_hash) begin miscompares++; $display("FAIL rand_hash[%0d]: got %h exp %h", n, hash_value, m_hash); end
            vectors++; if (finished !== m_fin) begin miscompares++; $display("FAIL rand_fin[%0d]: got %b exp %b", n, finished, m_fin); end
            vectors++; if (done_pulse !== m_pulse) begin miscompares++; $display("FAIL rand_pulse[%0d]: got %b exp %b", n, done_pulse, m_pulse); end
            vectors++; if (fault !== m_fault) begin miscompares++; $display("FAIL rand_fault[%0d]: got %b exp %b", n, fault, m_fault); end
            vectors++; if (valid_mask !== m_mask) begin miscompares++; $display("FAIL rand_mask[%0d]: got %h exp %h", n, valid_mask, m_mask); end
            vectors++; if (hash_cycles !== 32'(m_cnt)) begin miscompares++; $display("FAIL rand_cycles[%0d]: got %0d exp %0d", n, hash_cycles, m_cnt); end
            vectors++; if (int'(fsm_state) !== m_phase) begin miscompares++; $display("FAIL rand_state[%0d]: got %0d exp %0d", n, fsm_state, m_phase); end
            vectors++; if (hash_cycles4 !== ((m_cnt > 15) ? 4'd15 : 4'(m_cnt))) begin miscompares++; $display("FAIL rand_cycles4[%0d]: got %0d exp %0d", n, hash_cycles4, m_cnt); end
            vectors++; if ({hash_value4, finished4, done_pulse4, fault4, valid_mask4, fsm_state4} !== {m_hash, m_fin, m_pulse, m_fault, m_mask, 2'(m_phase)}) begin
                miscompares++; $display("FAIL rand_dut4[%0d]: got %b/%b/%b/%h exp %b/%b/%b/%h", n, finished4, done_pulse4, fault4, valid_mask4, m_fin, m_pulse, m_fault, m_mask);
            end
        end
    endtask

    task automatic async_reset_check(input string tag);
        wren = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        vectors++; if (hash_value !== 256'h0) begin miscompares++; $display("FAIL %s_hash: got %h exp 0", tag, hash_value); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL %s_fin: got %b exp 0", tag, finished); end
        vectors++; if (valid_mask !== 8'h0) begin miscompares++; $display("FAIL %s_mask: got %h exp 0", tag, valid_mask); end
        vectors++; if (hash_cycles !== 32'h0) begin miscompares++; $display("FAIL %s_cycles: got %0d exp 0", tag, hash_cycles); end
        vectors++; if ({done_pulse, fault} !== 2'b00) begin miscompares++; $display("FAIL %s_flags: got %b exp 00", tag, {done_pulse, fault}); end
        @(negedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_async_reset();
        step(1'b1, BASE + 12'd8, 32'h2);
        for (int i = 0; i < 5; i++) step(1'b1, BASE + 12'(i), $urandom);
        async_reset_check("rst_collect");
        step(1'b1, BASE + 12'd8, 32'h1);
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL rst_collect_refault: got %b exp 1", fault); end
        step(1'b1, BASE + 12'd8, 32'h2);
        for (int i = 0; i < 8; i++) step(1'b1, BASE + 12'(i), iv[i]);
        step(1'b1, BASE + 12'd8, 32'h1);
        vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL rst_pre_done: got %b exp 1", finished); end
        async_reset_check("rst_done");
        step(1'b1, BASE + 12'd8, 32'h1);
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL rst_done_refault: got %b exp 1", fault); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL rst_done_fin: got %b exp 0", finished); end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_commit();
        test_rewrite();
        test_partial();
        test_clear_priority();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end of test exp finish");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/hash_mailbox.md
# hash_mailbox

Memory-mapped result mailbox that sits on the processor's data-memory write port beside `RAM`. It snoops CPU stores to a small reserved word region and stages the eight 32-bit SHA-256 digest words. On a software commit it presents the completed 256-bit digest and a `finished` flag to the 7-segment display driver. It is the producing end of the display's `finished`/`hash_value` interface and also reports a hashing cycle count for benchmarking.

## Interface
Parameters:
- `BASE_ADDR`, 12'hF00: word address of digest word 0; the region is `BASE_ADDR`..`BASE_ADDR+8`.
- `CNT_W`, 32: width of the cycle counter.

Ports:
- `clock`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `wren`, in, 1: CPU data-memory write enable (same signal that drives `RAM.wEn`).
- `address_dmem`, in, 12: CPU data-memory word address (`memAddr[11:0]`).
- `data`, in, 32: CPU store data.
- `hash_value`, out, 256: committed digest; word 0 in [255:224], word 7 in [31:0].
- `finished`, out, 1: high while a valid committed digest is presented.
- `done_pulse`, out, 1: one-cycle strobe on each successful commit.
- `fault`, out, 1: sticky; set when a commit is attempted with words missing.
- `valid_mask`, out, 8: bit i set when staging word i has been written since the last clear.
- `hash_cycles`, out, CNT_W: cycles from the last clear or reset to the commit; saturating.

## Operation
- Decode: a hit requires `wren` high with `address_dmem` in `BASE_ADDR`..`BASE_ADDR+8`. Non-hits are ignored. The RAM still performs every write; this block never stalls or blocks it.
- Offsets 0..7 (digest word writes): `data` goes into staging word i and `valid_mask[i]` is set. Rewriting the same word overwrites it. These writes are accepted in every state.
- Offset 8 (control write), with clear taking priority:
  - `data[1]` = clear: empties the staging area, `valid_mask` ← 0, `finished` ← 0, `fault` ← 0, counter ← 0, state → COLLECT. `hash_value` keeps its old value but is not flagged.
  - `data[0]` = commit, only when `data[1]` = 0:
    - If `valid_mask` = 8'hFF: `hash_value` ← staging, `finished` ← 1, `done_pulse` ← 1 for one cycle, `hash_cycles` frozen, state → DONE.
    - Otherwise: `fault` ← 1, state → FAULT, outputs otherwise unchanged.
  - `data` = 0: no effect.
- States:
  - COLLECT: counter increments each cycle and saturates at all-ones.
  - DONE: counter holds. Further word writes change only the staging area and `valid_mask`, not `hash_value`, because the output is double-buffered. A new commit with a full mask re-presents the digest, pulses `done_pulse` again and keeps the frozen count.
  - FAULT: counter holds. Only a clear exits this state; a commit here is ignored.
- Reset: every register is cleared. Outputs are then `hash_value` = 0, `finished` = 0, `done_pulse` = 0, `fault` = 0, `valid_mask` = 0, `hash_cycles` = 0, state COLLECT. Reset asserted mid-collection discards all staged words.

## Timing
- A write is sampled at the rising edge that ends its bus cycle N. All outputs reflect it in cycle N+1, so latency is 1 cycle.
- `finished` rises in the same cycle that `hash_value` becomes valid, never earlier.
- `done_pulse` is high for exactly one cycle per successful commit.
- `hash_cycles` counts every COLLECT cycle, including the cycle in which the commit is sampled.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Only one bus write can occur per cycle, so there are no simultaneous hits. Priority inside a single control write is clear before commit.
- Reset release is not synchronised in this block; it relies on the board-level reset synchroniser.

## Structure
- Shared package `hash_mailbox_pkg`:
  - offset constants `OFF_WORD0`=0, `OFF_CTRL`=8;
  - control bit indices `CTRL_COMMIT`=0, `CTRL_CLEAR`=1;
  - state encoding COLLECT=2'd0, DONE=2'd1, FAULT=2'd2.
- No sub-module. Address decode, 8×32 staging bank, output buffer, FSM and counter are all in one module.

## Test plan
- Write words 0x6A09E667, 0xBB67AE85, …, 0x5BE0CD19 to offsets 0..7, then write 1 to offset 8. Required: `hash_value[255:224]` = 0x6A09E667, `finished` = 1 and a one-cycle `done_pulse` in the cycle after the commit, `valid_mask` = 8'hFF.
- Write only offsets 0..6, then commit. Required: `fault` = 1, `finished` = 0, `hash_value` unchanged. A later commit is ignored; writing 2 to offset 8 then clears `fault`.
- After a successful commit, write 0xDEADBEEF to offset 3. Required: `hash_value` unchanged and `finished` held at 1. Recommit. Required: bits [159:128] = 0xDEADBEEF.
- Write 3 to offset 8 (clear and commit together) with a full mask. Required: clear wins, so `valid_mask` = 0, `finished` = 0, no `done_pulse`.
- Start counting after reset release and commit exactly 100 cycles later. Required: `hash_cycles` = 100 and it stays frozen. Also check saturation with `CNT_W` = 4: the count holds at 15.
- Assert `reset` low asynchronously, mid-collection and again while in DONE. Required: all outputs go to 0 immediately, and the first commit afterwards faults.
